// File: rtl/p251_div.sv
// Sequential GF(251) divider: out = in_1 * in_2^249 mod 251 via square-and-multiply.
// Optional macro P251_DIV_ERR_EN adds a registered divide-by-zero flag (err).
module p251_div #(
    parameter int CONST_TIME = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_1,
    input  logic [7:0] in_2,
    output logic [7:0] out,
`ifdef P251_DIV_ERR_EN
    output logic       err,
`endif
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQ   = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [7:0] EXP = 8'd249;
    localparam logic [8:0] P   = 9'd251;

    logic [1:0] state;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] acc;
    logic [2:0] idx;

    // 2^8 == 5 (mod 251): fold the high byte twice, then one conditional subtract
    function automatic logic [7:0] mod_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        logic [10:0] t;
        logic [8:0]  u;
        p = 16'(x) * 16'(y);
        t = 11'(p[15:8]) * 11'd5 + 11'(p[7:0]);
        u = 9'(t[10:8]) * 9'd5 + 9'(t[7:0]);
        return (u >= P) ? 8'(u - P) : u[7:0];
    endfunction

    function automatic logic [7:0] reduce(input logic [7:0] x);
        return (x >= 8'd251) ? (x - 8'd251) : x;
    endfunction

    logic [7:0] sq_val;
    logic [7:0] mul_val;
    logic [7:0] fin_val;
    logic       ebit;

    always_comb begin
        ebit    = EXP[idx];
        sq_val  = mod_mul(acc, acc);
        mul_val = mod_mul(acc, ebit ? b : 8'd1);
        fin_val = mod_mul(acc, a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a     <= 8'd0;
            b     <= 8'd0;
            acc   <= 8'd1;
            idx   <= 3'd7;
            out   <= 8'd0;
            done  <= 1'b0;
`ifdef P251_DIV_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a     <= reduce(in_1);
                        b     <= reduce(in_2);
                        acc   <= 8'd1;
                        idx   <= 3'd7;
                        state <= S_SQ;
                    end
                end
                S_SQ: begin
                    acc <= sq_val;
                    if (CONST_TIME != 0 || ebit) begin
                        state <= S_MUL;
                    end else if (idx == 3'd0) begin
                        state <= S_FIN;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                S_MUL: begin
                    acc <= mul_val;
                    if (idx == 3'd0) begin
                        state <= S_FIN;
                    end else begin
                        idx   <= idx - 3'd1;
                        state <= S_SQ;
                    end
                end
                S_FIN: begin
                    out   <= fin_val;
                    done  <= 1'b1;
`ifdef P251_DIV_ERR_EN
                    err   <= (b == 8'd0);
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p251_div.sv
// Scoreboard bench for p251_div: one CONST_TIME=1 and one CONST_TIME=0 instance
// share stimulus; each has its own queue of expected results and latencies.
module tb_p251_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic [7:0] out1;
    logic [7:0] out0;
    logic       done1;
    logic       done0;
`ifdef P251_DIV_ERR_EN
    logic       err1;
    logic       err0;
`endif

    always #5 clk = ~clk;

    p251_div #(.CONST_TIME(1)) u_ct1 (
        .clk(clk), .rst(rst), .start(start),
        .in_1(in_1), .in_2(in_2), .out(out1),
`ifdef P251_DIV_ERR_EN
        .err(err1),
`endif
        .done(done1)
    );

    p251_div #(.CONST_TIME(0)) u_ct0 (
        .clk(clk), .rst(rst), .start(start),
        .in_1(in_1), .in_2(in_2), .out(out0),
`ifdef P251_DIV_ERR_EN
        .err(err0),
`endif
        .done(done0)
    );

    typedef struct {
        int am;
        int bm;
        int res;
        int zero;
        int cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int prev1 = 0;
    int prev0 = 0;

    task automatic chk(input string tag, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int inv;
        e.am = x % 251;
        e.bm = y % 251;
        inv = 0;
        for (int k = 1; k < 251; k++)
            if ((k * e.bm) % 251 == 1) inv = k;
        e.res  = (e.am * inv) % 251;
        e.zero = (e.bm == 0) ? 1 : 0;
        e.cyc  = 0;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && done1) begin
            chk("q1_nonempty", int'(q1.size() > 0), 1);
            chk("pulse1", prev1, 0);
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("out_ct1", int'(out1), e.res);
                chk("lat_ct1", cyc - e.cyc, 17);
                if (e.bm != 0) chk("inv_prop1", (int'(out1) * e.bm) % 251, e.am);
`ifdef P251_DIV_ERR_EN
                chk("err_ct1", int'(err1), e.zero);
`endif
            end
        end
        prev1 = int'(done1);
    end

    always @(negedge clk) begin
        if (!rst && done0) begin
            chk("q0_nonempty", int'(q0.size() > 0), 1);
            chk("pulse0", prev0, 0);
            if (q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("out_ct0", int'(out0), e.res);
                chk("lat_ct0", cyc - e.cyc, 15);
`ifdef P251_DIV_ERR_EN
                chk("err_ct0", int'(err0), e.zero);
`endif
            end
        end
        prev0 = int'(done0);
    end

    // called at a negedge; capture happens at the following posedge
    task automatic issue(input int x, input int y);
        exp_t e;
        e = model(x, y);
        e.cyc = cyc + 1;
        in_1  = 8'(x);
        in_2  = 8'(y);
        start = 1'b1;
        q1.push_back(e);
        q0.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done1();
        int got;
        got = 0;
        for (int n = 0; n < 40 && got == 0; n++) begin
            @(negedge clk);
            got = int'(done1);
        end
        chk("done_timeout", got, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in_1  = 8'd0;
        in_2  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_out1", int'(out1), 0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_out0", int'(out0), 0);
        chk("rst_done0", int'(done0), 0);
        rst = 1'b0;
        @(negedge clk);

        // directed, issued back-to-back in the IDLE cycle after FIN
        issue(1, 20);   wait_done1();
        issue(7, 20);   wait_done1();
        issue(250, 250); wait_done1();
        issue(5, 252);  wait_done1();
        issue(9, 0);    wait_done1();
        issue(1, 20);   wait_done1();
        repeat (3) @(negedge clk);

        // reset during an operation: no done, out cleared
        issue(1, 20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out1", int'(out1), 0);
        chk("midrst_done1", int'(done1), 0);
        chk("midrst_out0", int'(out0), 0);
        q1.delete();
        q0.delete();
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(1, 20); wait_done1();
        repeat (2) @(negedge clk);

        // start while busy must be ignored
        issue(1, 20);
        repeat (3) @(negedge clk);
        in_1  = 8'd7;
        in_2  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done1();
        repeat (25) @(negedge clk);

        // random back-to-back sweep
        for (int i = 0; i < 150; i++) begin
            issue(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
            wait_done1();
        end
        repeat (25) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q0_drained", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/p251_div.md
Name: p251_div

Overview:
- Sequential GF(251) divider: computes out = in_1 * in_2^(-1) mod 251 using the same start/done handshake as the p251_mul and gf_mul arithmetic units.
- Inverse by Fermat exponentiation, in_2^249 mod 251, as left-to-right square-and-multiply over a single internal one-cycle modular multiplier, then one final multiply by in_1.
- Used wherever p251 arithmetic needs division: normalisation, solving, and check-side recomputation.

Parameters:
- CONST_TIME, 1: 1 = every exponent bit costs a square cycle plus a multiply cycle, giving fixed latency; 0 = multiply cycle skipped for zero exponent bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- in_1  input  8  dividend.
- in_2  input  8  divisor.
- out  output  8  quotient, registered; holds until the next result.
- done  output  1  one-cycle pulse; out is valid when done=1.

Behaviour:
- Reset (async, rst=1): state=IDLE, out=0, done=0, internal accumulator=1, bit index=7. Reset mid-operation aborts silently with no done pulse.
- Operand capture at the edge where IDLE and start=1:
  - a = in_1 mod 251, b = in_2 mod 251; inputs 251..255 wrap to 0..4.
  - acc = 1, idx = 7, state goes to SQ.
- States: IDLE, SQ, MUL, FIN.
- SQ: acc <= acc*acc mod 251.
  - CONST_TIME=1: next state is always MUL.
  - CONST_TIME=0: next state is MUL if E[idx]=1. Otherwise idx decrements and the state stays SQ, or goes to FIN when idx=0.
- MUL: acc <= (E[idx] ? acc*b : acc*1) mod 251, where E = 249 = 8'b11111001. Then idx=0 goes to FIN, else idx decrements and the state goes to SQ.
- FIN: out <= acc*a mod 251, done <= 1, state goes to IDLE.
- done is registered and high for exactly one cycle after the FIN edge; otherwise 0.
- Latency, counted in cycles from the capture edge to done high:
  - CONST_TIME=1: 17 (8 SQ + 8 MUL + FIN).
  - CONST_TIME=0: 15 (8 SQ + 6 MUL + FIN).
- Modular multiply: 8x8 product to 16 bits, fully reduced to the range 0..250 within the same cycle. out never exceeds 250.
- Divide by zero (b=0): the exponentiation yields 0, so out=0 after normal latency. done still pulses; no early exit, so timing stays input-independent.
- start while not IDLE: ignored, with no queuing. start in the IDLE cycle directly after FIN is accepted, allowing back-to-back operation with 1-cycle spacing.
- in_1 and in_2 may change freely after the capture edge.

Optional Feature:
- Macro: P251_DIV_ERR_EN.
- Defined: adds output port err (1 bit, reset 0). err is registered at FIN, equals (b==0), and is valid with done. It holds with out until the next FIN.
- Undefined: no err port and no zero-detect logic. Divide by zero still yields out=0.

Test Plan:
- rst low, start pulse with in_1=1, in_2=20 → done after 17 cycles (CONST_TIME=1), out=113.
- in_1=7, in_2=20 → out=38. Repeat with CONST_TIME=0 → out=38, done after 15 cycles.
- in_1=250, in_2=250 → out=1. Then in_1=5, in_2=252 (wraps to 1) → out=5.
- in_1=9, in_2=0 → out=0, done pulses. With P251_DIV_ERR_EN, err=1. A following in_1=1, in_2=20 clears err to 0 with out=113.
- Reset and busy handling:
  - Assert rst at cycle 6 of an operation → out=0, done never pulses.
  - After release, a new request in_1=1, in_2=20 → out=113.
  - start re-pulsed with in_2=3 during busy → ignored; the result is still for the first operands.
- Randomised sweep, all in_1 and all in_2≠0 → out*in_2 mod 251 == in_1 mod 251. done is exactly one cycle wide.
